// File: rtl/bin_to_bcd_dabble.sv
// rtl/bin_to_bcd_dabble.sv - sequential double-dabble binary to packed BCD converter
// Optional overflow output enabled by defining BIN_TO_BCD_OVF_EN.
module bin_to_bcd_dabble #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN_TO_BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   scratch_shift;

`ifdef BIN_TO_BCD_OVF_EN
  logic            ovf_q, ovf_d;
  logic            ovf_flag_q, ovf_flag_d;
`endif

  // All digits adjust from their pre-adjust values; inputs are <=9 so no carry out.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_shift = (adj << 1) | SW'(src_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_d     = src_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
`ifdef BIN_TO_BCD_OVF_EN
    ovf_flag_d = ovf_flag_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d     = bin;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
`ifdef BIN_TO_BCD_OVF_EN
          ovf_flag_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        src_d     = src_q << 1;
        scratch_d = scratch_shift;
        cnt_d     = cnt_q - CNT_ONE;
`ifdef BIN_TO_BCD_OVF_EN
        ovf_flag_d = ovf_flag_q | adj[SW-1];
`endif
      end
      default: ;
    endcase
  end

  // Outputs are registered from the next state so bcd only ever shows a final result.
  always_comb begin
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
    bcd_d  = bcd_q;
`ifdef BIN_TO_BCD_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (state_q == SHIFT && state_d == DONE) begin
      bcd_d = scratch_shift;
`ifdef BIN_TO_BCD_OVF_EN
      ovf_d = ovf_flag_q | adj[SW-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef BIN_TO_BCD_OVF_EN
      ovf_q      <= 1'b0;
      ovf_flag_q <= 1'b0;
`endif
    end else begin
      src_q     <= src_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
`ifdef BIN_TO_BCD_OVF_EN
      ovf_q      <= ovf_d;
      ovf_flag_q <= ovf_flag_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BIN_TO_BCD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
